msg_schedule: RTL and testbench

- Downstream neighbour of the padding stage.
- Reads the padded 32-bit message words from the padding register file through its read-address port and produces the SHA-256 message schedule W[0..63], one word per accepted handshake, for each 512-bit block.
- Handles 1 or 2 blocks as indicated by the padding stage's block-count output, and feeds the compression-round stage.

---
 rtl/msg_schedule.sv | 154 +++++++++++++++
 tb/tb_msg_schedule.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msg_schedule.sv
// SHA-256 message schedule generator.
// Streams W[0..63] for one or two 512-bit blocks read from the padding
// register file, one word per valid/ready handshake.
// Optional feature macro: MSG_SCHED_BLOCK_PAUSE_EN (adds next_blk and a
// WAIT_NXT state that holds off block 1 until the compressor is ready).
module msg_schedule #(
    parameter int ADDR_W = 5,
    parameter int WORD_W = 32,
    parameter int ROUNDS = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        blocks_num,
`ifdef MSG_SCHED_BLOCK_PAUSE_EN
    input  logic              next_blk,
`endif
    output logic [ADDR_W-1:0] addr_rd,
    input  logic [WORD_W-1:0] padded_message,
    output logic [WORD_W-1:0] w_out,
    output logic              w_valid,
    input  logic              w_ready,
    output logic [5:0]        t_idx,
    output logic              blk_idx,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        EXPAND   = 3'd2,
        FIN      = 3'd3,
        WAIT_NXT = 3'd4
    } state_t;

    localparam logic [5:0] T_LAST   = 6'(ROUNDS - 1);
    localparam logic [3:0] LOAD_END = 4'd15;

    state_t            state;
    logic              two_blk;
    logic [WORD_W-1:0] win [16];
    logic [WORD_W-1:0] expand_word;
    logic              accept;

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    assign expand_word = sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0];
    assign accept      = w_valid && w_ready;

    // Output word mux: pass-through while loading, recurrence while expanding
    always_comb begin
        w_out   = '0;
        w_valid = 1'b0;
        case (state)
            LOAD: begin
                w_out   = padded_message;
                w_valid = 1'b1;
            end
            EXPAND: begin
                w_out   = expand_word;
                w_valid = 1'b1;
            end
            default: begin
                w_out   = '0;
                w_valid = 1'b0;
            end
        endcase
    end

    // Control FSM, index/address counters and the 16-word sliding window
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            two_blk <= 1'b0;
            addr_rd <= '0;
            t_idx   <= '0;
            blk_idx <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            for (int i = 0; i < 16; i++) win[i] <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                for (int i = 0; i < 15; i++) win[i] <= win[i+1];
                win[15] <= w_out;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        // Only bit 0 selects the block count; bit 1 is don't-care.
                        two_blk <= blocks_num[0] | (blocks_num[1] & 1'b0);
                        blk_idx <= 1'b0;
                        t_idx   <= '0;
                        addr_rd <= '0;
                        busy    <= 1'b1;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        t_idx <= t_idx + 6'd1;
                        if (t_idx[3:0] == LOAD_END) begin
                            // Address stays on the last loaded word during expansion.
                            state <= EXPAND;
                        end else begin
                            addr_rd <= ADDR_W'({blk_idx, t_idx[3:0] + 4'd1});
                        end
                    end
                end
                EXPAND: begin
                    if (accept) begin
                        if (t_idx == T_LAST) begin
                            if (two_blk && !blk_idx) begin
                                t_idx   <= '0;
                                blk_idx <= 1'b1;
                                addr_rd <= ADDR_W'({1'b1, 4'h0});
`ifdef MSG_SCHED_BLOCK_PAUSE_EN
                                state   <= WAIT_NXT;
`else
                                state   <= LOAD;
`endif
                            end else begin
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= FIN;
                            end
                        end else begin
                            t_idx <= t_idx + 6'd1;
                        end
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
`ifdef MSG_SCHED_BLOCK_PAUSE_EN
                WAIT_NXT: begin
                    if (next_blk) state <= LOAD;
                end
`endif
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_msg_schedule.sv
// Testbench for msg_schedule: random message images and random consumer
// back-pressure, compared against a plain-arithmetic SHA-256 schedule model.
module tb_msg_schedule;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  blocks_num;
    logic [4:0]  addr_rd;
    logic [31:0] padded_message;
    logic [31:0] w_out;
    logic        w_valid;
    logic        w_ready;
    logic [5:0]  t_idx;
    logic        blk_idx;
    logic        busy;
    logic        done;
`ifdef MSG_SCHED_BLOCK_PAUSE_EN
    logic        next_blk;
    localparam bit PAUSE = 1'b1;
`else
    localparam bit PAUSE = 1'b0;
`endif

    logic [31:0] mem   [0:31];
    logic [31:0] exp_w [0:127];
    logic [31:0] got_w [0:127];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign padded_message = mem[addr_rd];

    msg_schedule dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .blocks_num     (blocks_num),
`ifdef MSG_SCHED_BLOCK_PAUSE_EN
        .next_blk       (next_blk),
`endif
        .addr_rd        (addr_rd),
        .padded_message (padded_message),
        .w_out          (w_out),
        .w_valid        (w_valid),
        .w_ready        (w_ready),
        .t_idx          (t_idx),
        .blk_idx        (blk_idx),
        .busy           (busy),
        .done           (done)
    );

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Reference schedule for both blocks straight from the SHA-256 definition
    task automatic build_model();
        for (int b = 0; b < 2; b++) begin
            for (int t = 0; t < 64; t++) begin
                int k;
                k = b * 64 + t;
                if (t < 16) exp_w[k] = mem[b * 16 + t];
                else exp_w[k] = ssig1(exp_w[k-2]) + exp_w[k-7] + ssig0(exp_w[k-15]) + exp_w[k-16];
            end
        end
    endtask

    task automatic load_abc();
        for (int i = 0; i < 32; i++) mem[i] = (i < 16) ? 32'h0 : $urandom;
        mem[0]  = 32'h61626380;
        mem[15] = 32'h00000018;
        build_model();
    endtask

    task automatic load_rand();
        for (int i = 0; i < 32; i++) mem[i] = $urandom;
        build_model();
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (addr_rd !== 5'd0 || w_out !== 32'd0 || w_valid !== 1'b0 || t_idx !== 6'd0 ||
            blk_idx !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s: addr=%0d w=%h v=%b t=%0d b=%b busy=%b done=%b, required all zero",
                     tag, addr_rd, w_out, w_valid, t_idx, blk_idx, busy, done);
        end
    endtask

    // One complete run; abort_at >= 0 asserts reset while word abort_at is presented
    task automatic run_msg(input bit two, input bit rand_rdy, input int abort_at, input bit poke);
        int nw, acc, vcyc, dones, cyc, waitc, ea;
        bit prev_stall, rdy;
        logic [31:0] pw;
        logic [5:0]  pt;
        logic        pb;
        logic [4:0]  pa;
        nw = two ? 128 : 64;
        acc = 0; vcyc = 0; dones = 0; cyc = 0; waitc = 0;
        prev_stall = 1'b0;
        pw = '0; pt = '0; pb = 1'b0; pa = '0;
        @(negedge clk);
        start = 1'b1;
        blocks_num = {1'($urandom & 1), two};
        w_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        while (acc < nw && cyc < 4000) begin
            if (done) dones++;
            if (w_valid) begin
                vcyc++;
                if (prev_stall) begin
                    checks++;
                    if (w_out !== pw || t_idx !== pt || blk_idx !== pb || addr_rd !== pa) begin
                        errors++;
                        $display("FAIL stall_hold: w=%h t=%0d b=%b a=%0d, required w=%h t=%0d b=%b a=%0d",
                                 w_out, t_idx, blk_idx, addr_rd, pw, pt, pb, pa);
                    end
                end
                if (PAUSE && acc == 64) begin
                    checks++;
                    if (waitc != 3) begin
                        errors++;
                        $display("FAIL pause_wait: block 1 began after %0d idle cycles, required 3", waitc);
                    end
                end
                ea = (acc / 64) * 16 + (((acc % 64) < 16) ? (acc % 64) : 15);
                checks++;
                if (w_out !== exp_w[acc] || t_idx !== 6'(acc % 64) || blk_idx !== 1'(acc / 64) ||
                    addr_rd !== 5'(ea) || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL word%0d: w=%h t=%0d b=%b a=%0d busy=%b, required w=%h t=%0d b=%0d a=%0d busy=1",
                             acc, w_out, t_idx, blk_idx, addr_rd, busy, exp_w[acc], acc % 64, acc / 64, ea);
                end
                got_w[acc] = w_out;
                rdy = rand_rdy ? 1'($urandom & 1) : 1'b1;
                if (abort_at == acc) begin
                    rst = 1'b0;
                    w_ready = rdy;
                    @(negedge clk);
                    rst = 1'b1;
                    w_ready = 1'b0;
                    check_reset_outputs("abort_reset");
                    @(negedge clk);
                    check_reset_outputs("abort_after");
                    return;
                end
                w_ready = rdy;
                prev_stall = !rdy;
                pw = w_out; pt = t_idx; pb = blk_idx; pa = addr_rd;
                if (rdy) acc++;
            end else begin
                prev_stall = 1'b0;
                if (PAUSE && acc == 64) begin
                    waitc++;
                    checks++;
                    if (busy !== 1'b1) begin
                        errors++;
                        $display("FAIL pause_busy: busy=%b, required 1", busy);
                    end
`ifdef MSG_SCHED_BLOCK_PAUSE_EN
                    next_blk = (waitc == 3);
`endif
                end else begin
                    checks++;
                    errors++;
                    $display("FAIL gap: w_valid=0 after %0d words, required 1", acc);
                end
            end
            start = (poke && acc == 20) ? 1'b1 : 1'b0;
            if (poke && acc == 20) blocks_num = two ? 2'b10 : 2'b11;
            @(negedge clk);
`ifdef MSG_SCHED_BLOCK_PAUSE_EN
            next_blk = 1'b0;
`endif
            cyc++;
        end
        w_ready = 1'b0;
        start = 1'b0;
        checks++;
        if (acc != nw) begin
            errors++;
            $display("FAIL timeout: %0d words accepted, required %0d", acc, nw);
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL early_done: %0d pulses during run, required 0", dones);
        end
        if (!rand_rdy) begin
            checks++;
            if (vcyc != nw) begin
                errors++;
                $display("FAIL valid_cycles: %0d, required %0d", vcyc, nw);
            end
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || w_valid !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: done=%b busy=%b v=%b, required done=1 busy=0 v=0", done, busy, w_valid);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_width: done=%b busy=%b, required 0 0", done, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        w_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_state");
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("idle_no_start");
        w_ready = 1'b0;
    endtask

    task automatic test_abc();
        load_abc();
        run_msg(1'b0, 1'b0, -1, 1'b0);
        checks++;
        if (got_w[0] !== 32'h61626380 || got_w[15] !== 32'h00000018 || got_w[16] !== 32'h61626380 ||
            got_w[17] !== 32'h000F0000 || got_w[18] !== 32'h7DA86405 || got_w[63] !== 32'h12B1EDEB) begin
            errors++;
            $display("FAIL abc_known: W0=%h W15=%h W16=%h W17=%h W18=%h W63=%h, required 61626380 00000018 61626380 000f0000 7da86405 12b1edeb",
                     got_w[0], got_w[15], got_w[16], got_w[17], got_w[18], got_w[63]);
        end
    endtask

    task automatic test_stall();
        load_abc();
        run_msg(1'b0, 1'b1, -1, 1'b0);
        load_rand();
        run_msg(1'b0, 1'b1, -1, 1'b0);
    endtask

    task automatic test_two_block();
        load_rand();
        run_msg(1'b1, 1'b0, -1, 1'b0);
        load_rand();
        run_msg(1'b1, 1'b1, -1, 1'b0);
    endtask

    task automatic test_abort_restart();
        load_abc();
        run_msg(1'b0, 1'b1, 30, 1'b0);
        run_msg(1'b0, 1'b0, -1, 1'b0);
        checks++;
        if (got_w[63] !== 32'h12B1EDEB) begin
            errors++;
            $display("FAIL restart_w63: %h, required 12b1edeb", got_w[63]);
        end
    endtask

    task automatic test_ignore_start();
        load_rand();
        run_msg(1'b0, 1'b1, -1, 1'b1);
        load_rand();
        run_msg(1'b1, 1'b0, -1, 1'b1);
    endtask

`ifdef MSG_SCHED_BLOCK_PAUSE_EN
    task automatic test_pause();
        load_rand();
        run_msg(1'b1, 1'b1, -1, 1'b0);
    endtask
`endif

    initial begin
        rst = 1'b0;
        start = 1'b0;
        blocks_num = 2'b00;
        w_ready = 1'b0;
`ifdef MSG_SCHED_BLOCK_PAUSE_EN
        next_blk = 1'b0;
`endif
        for (int i = 0; i < 32; i++) mem[i] = '0;
        test_reset();
        test_abc();
        test_stall();
        test_two_block();
        test_abort_restart();
        test_ignore_start();
`ifdef MSG_SCHED_BLOCK_PAUSE_EN
        test_pause();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
